intfdemux_syncctl: RTL
======================

Name: intfdemux_syncctl

Overview:
- Frame-alignment controller that sequences the 6:1 line demultiplexer on the inter-FPGA interface.
- Hunts for a sync word in the incoming LINEBIT-wide line stream, confirms alignment over several frames, then flywheels.
- Drives a one-cycle frame strobe with a matching delayed data stream to the demux (`idat`/`isyn` inputs).
- Reports lock state and a saturating sync-error count to the management layer.

Parameters:
- `LINEBIT`, 12, width of the line word.
- `DEMUX`, 6, words per frame (2..8); the sync word occupies frame phase 0.
- `SYNWORD`, 12'hA5C, sync pattern; width LINEBIT.
- `CONFIRM`, 3, consecutive phase-0 matches required to declare lock (1..7).
- `LOSS`, 4, consecutive phase-0 misses that drop lock (1..7).

Ports:
- `iclk38`, in, 1, line clock; all logic on rising edge.
- `rst_`, in, 1, synchronous active-low reset.
- `idat`, in, LINEBIT, raw line word.
- `ienable`, in, 1, 0 forces HUNT and holds outputs quiet.
- `iclrerr`, in, 1, clears `oerrcnt` (one-cycle pulse).
- `odat`, out, LINEBIT, `idat` delayed one cycle; feeds demux `idat`.
- `osyn`, out, 1, frame strobe aligned to phase-0 word on `odat`; feeds demux `isyn`.
- `olock`, out, 1, 1 while in SYNC.
- `ostate`, out, 2, 0 = HUNT, 1 = PRESYNC, 2 = SYNC.
- `ophase`, out, 3, current frame phase 0..DEMUX-1, aligned with `odat`.
- `oerrcnt`, out, 8, saturating count of phase-0 misses while in SYNC.

Behaviour:
- **Reset** (`rst_`=0 at edge):
  - state HUNT.
  - phase counter 0, hit counter 0, miss counter 0.
  - `odat`=0, `osyn`=0, `olock`=0, `ostate`=0, `ophase`=0, `oerrcnt`=0.
  - Reset mid-frame discards alignment with no residual strobe.
- **Data path:** `odat` <= `idat` every cycle regardless of state.
- **Internal phase `ph`:**
  - Wraps DEMUX-1 -> 0.
  - Free-runs in PRESYNC and SYNC; holds 0 in HUNT.
  - Forced to 1 on the cycle after a HUNT match.
- **Outputs registered from internal state:** `ophase` <= `ph`; `osyn`/`odat` thus see one-cycle latency.
- **Match** (`m`): `idat == SYNWORD`, evaluated combinationally on the current word.
- **HUNT:**
  - Every cycle, if `m`: `ph`<=1, hit<=1, go PRESYNC.
  - If `CONFIRM`=1, go directly to SYNC instead.
- **PRESYNC**, evaluated only when `ph`==0:
  - `m`: hit+1; if hit+1 == CONFIRM, go SYNC and miss<=0.
  - Not `m`: go HUNT, hit<=0, `ph`<=0.
  - A HUNT-style rematch is not attempted in the same cycle.
- **SYNC**, evaluated when `ph`==0:
  - `m`: miss<=0.
  - Not `m`: miss+1 and `oerrcnt`+1 (saturate at 255).
  - If miss+1 == LOSS: go HUNT, `ph`<=0, miss<=0.
- **`osyn`** <= (state==SYNC && `ph`==0 && `ienable`), independent of `m`, so it flywheels through isolated misses.
  - The strobe is also issued on the miss cycle that causes loss of lock, because state is still SYNC there.
  - `olock` falls on the following edge.
- **`olock`** <= (next state == SYNC); `ostate` likewise tracks the next state.
- **`ienable`=0:** next state HUNT, `ph`=0, hit/miss=0, `osyn`=0. `oerrcnt` is held.
- **`iclrerr`=1:** `oerrcnt`<=0. Clear wins over a simultaneous increment.
- **Sync word in payload phases (1..DEMUX-1):** ignored in PRESYNC and SYNC.
- **Downstream contract:** with demux `DEMUX` equal to this block's, the demux output word holds {phase0..phase5} with phase 0 in the MSB slot.

Test Plan:
- **Lock acquisition:** reset, `ienable`=1; send 5 random non-matching words, then frames with 12'hA5C at phase 0 and payload 1..5. Required:
  - `ostate` 0 -> 1 on the cycle after the first 12'hA5C.
  - 2 on the cycle after the 3rd sync word.
  - First `osyn` on the 4th frame's phase-0 `odat`.
  - `ophase` cycles 0..5.
- **False sync rejection:** 12'hA5C at an arbitrary point, then no sync word at the 6-word boundary -> PRESYNC then HUNT; `osyn` never asserted; `olock`=0.
- **Flywheel and loss:** in SYNC, corrupt 3 consecutive sync words then restore. Required:
  - `osyn` keeps pulsing every 6 cycles; `olock` stays 1; `oerrcnt`=3.
  - Corrupt 4 consecutive: `olock` drops on the edge after the 4th miss; `oerrcnt`=7.
- **Error counter:** hold SYNC with permanent misses and `LOSS`=7, relocking repeatedly until `oerrcnt` reaches 255. Required:
  - `oerrcnt` saturates at 255.
  - `iclrerr` pulse coincident with a miss -> `oerrcnt`=0.
- **Enable and reset mid-frame:** in SYNC at `ph`=3, drop `ienable` for 1 cycle -> HUNT, `osyn`=0, `oerrcnt` held. Repeat with `rst_`=0 -> all outputs 0 on the next edge.
- **Demux integration:** connect to the 6:1 demux; send sync + words 12'h001..12'h005 -> after lock, demux output = {A5C,001,002,003,004,005} once per frame.

Source files
------------

// File: rtl/intfdemux_syncctl.sv
// Frame-alignment controller for the 6:1 line demux: hunts for the sync word, confirms it
// over several frames, then flywheels and drives a one-cycle frame strobe with delayed data.
module intfdemux_syncctl #(
    parameter int unsigned         LINEBIT = 12,
    parameter int unsigned         DEMUX   = 6,
    parameter logic [LINEBIT-1:0]  SYNWORD = 12'hA5C,
    parameter int unsigned         CONFIRM = 3,
    parameter int unsigned         LOSS    = 4
) (
    input  logic               iclk38,
    input  logic               rst_,
    input  logic [LINEBIT-1:0] idat,
    input  logic               ienable,
    input  logic               iclrerr,
    output logic [LINEBIT-1:0] odat,
    output logic               osyn,
    output logic               olock,
    output logic [1:0]         ostate,
    output logic [2:0]         ophase,
    output logic [7:0]         oerrcnt
);

    typedef enum logic [1:0] {
        StHunt    = 2'd0,
        StPresync = 2'd1,
        StSync    = 2'd2
    } state_e;

    localparam logic [2:0] PhLast   = 3'(DEMUX - 1);
    localparam logic [2:0] ConfirmW = 3'(CONFIRM);
    localparam logic [2:0] LossW    = 3'(LOSS);

    state_e     state_q, state_d;
    logic [2:0] ph_q, ph_d;
    logic [2:0] hit_q, hit_d;
    logic [2:0] miss_q, miss_d;
    logic [7:0] err_d;
    logic       err_inc;
    logic       syn_d;
    logic       m;
    logic       at_frame;
    logic [2:0] ph_adv;

    assign m        = (idat == SYNWORD);
    assign at_frame = (ph_q == 3'd0);
    assign ph_adv   = (ph_q == PhLast) ? 3'd0 : ph_q + 3'd1;

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        err_inc = 1'b0;

        unique case (state_q)
            StHunt: begin
                ph_d = 3'd0;
                if (m) begin
                    // Matched word is phase 0, so the next word is phase 1
                    ph_d    = 3'd1;
                    hit_d   = 3'd1;
                    miss_d  = 3'd0;
                    state_d = (CONFIRM == 1) ? StSync : StPresync;
                end
            end
            StPresync: begin
                ph_d = ph_adv;
                if (at_frame) begin
                    if (m) begin
                        hit_d = hit_q + 3'd1;
                        if (hit_q + 3'd1 == ConfirmW) begin
                            state_d = StSync;
                            miss_d  = 3'd0;
                        end
                    end else begin
                        state_d = StHunt;
                        hit_d   = 3'd0;
                        ph_d    = 3'd0;
                    end
                end
            end
            StSync: begin
                ph_d = ph_adv;
                if (at_frame) begin
                    if (m) begin
                        miss_d = 3'd0;
                    end else begin
                        err_inc = 1'b1;
                        if (miss_q + 3'd1 == LossW) begin
                            state_d = StHunt;
                            ph_d    = 3'd0;
                            miss_d  = 3'd0;
                        end else begin
                            miss_d = miss_q + 3'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = StHunt;
                ph_d    = 3'd0;
            end
        endcase

        if (!ienable) begin
            state_d = StHunt;
            ph_d    = 3'd0;
            hit_d   = 3'd0;
            miss_d  = 3'd0;
            err_inc = 1'b0;
        end
    end

    // Clear has priority over a coincident miss increment
    always_comb begin
        err_d = oerrcnt;
        if (iclrerr) begin
            err_d = 8'd0;
        end else if (err_inc && oerrcnt != 8'hFF) begin
            err_d = oerrcnt + 8'd1;
        end
    end

    // Strobe depends only on position, so it flywheels through isolated misses
    assign syn_d = (state_q == StSync) && at_frame && ienable;

    always_ff @(posedge iclk38) begin
        if (!rst_) begin
            state_q <= StHunt;
            ph_q    <= 3'd0;
            hit_q   <= 3'd0;
            miss_q  <= 3'd0;
            odat    <= '0;
            osyn    <= 1'b0;
            olock   <= 1'b0;
            ophase  <= 3'd0;
            oerrcnt <= 8'd0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            odat    <= idat;
            osyn    <= syn_d;
            olock   <= (state_d == StSync);
            ophase  <= ph_q;
            oerrcnt <= err_d;
        end
    end

    assign ostate = state_q;

endmodule
